status_flag_unit: RTL and testbench

- Producer side of the NZCV interface: generates and holds the processor status flags that the condition checker consumes in the ID stage.
- Derives N/Z/C/V from EX-stage ALU results when the instruction's S bit is set, and registers them.
- Offers a forwarded view so the ID stage sees flags written by the instruction currently in EX.
- Provides a single-entry saved-status slot (exception entry save / return restore) and a direct-write port.

---
 rtl/status_flag_unit_pkg.sv | 18 +
 rtl/status_flag_unit_flag_gen.sv | 36 +++
 rtl/status_flag_unit.sv | 100 ++++++++++
 tb/tb_status_flag_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/status_flag_unit_pkg.sv
// -----------------------------------------------------------------------------
// status_flag_unit_pkg
// Purpose : Shared definitions for the NZCV status flags. The producer
//           (status_flag_unit) and the ID-stage condition checker both use
//           them.
// Contents: flag bit positions within the 4-bit status word {N,Z,C,V}, and
//           the status word typedef.
// -----------------------------------------------------------------------------
package status_flag_unit_pkg;

   localparam int N_IDX = 3;
   localparam int Z_IDX = 2;
   localparam int C_IDX = 1;
   localparam int V_IDX = 0;

   typedef logic [3:0] status_t;

endpackage : status_flag_unit_pkg

// File: rtl/status_flag_unit_flag_gen.sv
// -----------------------------------------------------------------------------
// status_flag_unit_flag_gen
// Purpose : Combinational NZCV generator for the EX-stage ALU result.
// Ports   : alu_result_i  ALU result (DATA_WIDTH bits)
//           arith_i       1 = arithmetic op, 0 = logical op
//           alu_c_i       ALU carry-out
//           alu_v_i       ALU overflow
//           shift_c_i     barrel-shifter carry-out
//           v_in_i        current V flag, kept for logical ops
//           flags_o       generated {N,Z,C,V}
// -----------------------------------------------------------------------------
module status_flag_unit_flag_gen
   import status_flag_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] alu_result_i,
   input  logic                  arith_i,
   input  logic                  alu_c_i,
   input  logic                  alu_v_i,
   input  logic                  shift_c_i,
   input  logic                  v_in_i,
   output status_t               flags_o
);

   always_comb begin
      flags_o        = '0;
      flags_o[N_IDX] = alu_result_i[DATA_WIDTH-1];
      // Zero detect spans the whole result width.
      flags_o[Z_IDX] = (alu_result_i == '0);
      // Logical ops take C from the shifter and leave V untouched.
      flags_o[C_IDX] = arith_i ? alu_c_i : shift_c_i;
      flags_o[V_IDX] = arith_i ? alu_v_i : v_in_i;
   end

endmodule : status_flag_unit_flag_gen

// File: rtl/status_flag_unit.sv
// -----------------------------------------------------------------------------
// status_flag_unit
// Purpose : Produces and holds the processor NZCV flags. The flags are
//           updated from EX-stage ALU results, by direct writes, or by a
//           restore from the single-entry saved-status slot. A forwarded view
//           lets ID see the flags the EX instruction is about to write.
// Ports   : clk, rst            clock, synchronous active-high reset
//           freeze              stall: holds all state this cycle
//           flush               cancels the EX flag update this cycle
//           s_upd, arith        EX flag update request and op class
//           alu_result, alu_c, alu_v, shift_c   EX flag sources
//           wr_en, wr_data      direct status write
//           save_en, restore_en saved-slot save / restore
//           status              registered {N,Z,C,V}
//           status_fwd          forwarded status (next value when FORWARD_EN)
//           saved_status        saved slot contents
//           saved_valid         saved slot holds data not yet restored
// -----------------------------------------------------------------------------
module status_flag_unit
   import status_flag_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter bit FORWARD_EN = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  freeze,
   input  logic                  flush,
   input  logic                  s_upd,
   input  logic                  arith,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_c,
   input  logic                  alu_v,
   input  logic                  shift_c,
   input  logic                  wr_en,
   input  logic [3:0]            wr_data,
   input  logic                  save_en,
   input  logic                  restore_en,
   output logic [3:0]            status,
   output logic [3:0]            status_fwd,
   output logic [3:0]            saved_status,
   output logic                  saved_valid
);

   status_t status_q, status_d;
   status_t saved_q;
   logic    saved_vld_q;
   status_t gen_flags;
   logic    restore_hit;

   status_flag_unit_flag_gen #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_flag_gen (
      .alu_result_i (alu_result),
      .arith_i      (arith),
      .alu_c_i      (alu_c),
      .alu_v_i      (alu_v),
      .shift_c_i    (shift_c),
      .v_in_i       (status_q[V_IDX]),
      .flags_o      (gen_flags)
   );

   // A restore with an empty slot is silently ignored.
   assign restore_hit = restore_en & saved_vld_q;

   always_comb begin
      status_d = status_q;
      if (restore_hit) begin
         status_d = saved_q;
      end else if (wr_en) begin
         status_d = wr_data;
      end else if (s_upd && !flush) begin
         status_d = gen_flags;
      end
   end

   // Save captures the pre-update status. A simultaneous restore has already
   // read the old slot through status_d, so the slot can be overwritten.
   always_ff @(posedge clk) begin
      if (rst) begin
         status_q    <= '0;
         saved_q     <= '0;
         saved_vld_q <= 1'b0;
      end else if (!freeze) begin
         status_q <= status_d;
         if (save_en) begin
            saved_q     <= status_q;
            saved_vld_q <= 1'b1;
         end else if (restore_hit) begin
            saved_vld_q <= 1'b0;
         end
      end
   end

   assign status       = status_q;
   assign status_fwd   = (FORWARD_EN && !freeze) ? status_d : status_q;
   assign saved_status = saved_q;
   assign saved_valid  = saved_vld_q;

endmodule : status_flag_unit

// File: tb/tb_status_flag_unit.sv
// -----------------------------------------------------------------------------
// tb_status_flag_unit
// A reference model predicts the flags. Each driven cycle pushes its
// expectations into a queue. A monitor pops them on the falling edge: it
// checks status_fwd against the current cycle, and the registered outputs
// against the previous cycle's predicted post-edge state.
// -----------------------------------------------------------------------------
module tb_status_flag_unit;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst, freeze, flush, s_upd, arith, alu_c, alu_v, shift_c;
   logic [DW-1:0] alu_result;
   logic          wr_en, save_en, restore_en;
   logic [3:0]    wr_data;
   logic [3:0]    status, status_fwd, saved_status;
   logic          saved_valid;

   always #5 clk = ~clk;

   status_flag_unit #(.DATA_WIDTH(DW), .FORWARD_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .s_upd(s_upd),
      .arith(arith), .alu_result(alu_result), .alu_c(alu_c), .alu_v(alu_v),
      .shift_c(shift_c), .wr_en(wr_en), .wr_data(wr_data), .save_en(save_en),
      .restore_en(restore_en), .status(status), .status_fwd(status_fwd),
      .saved_status(saved_status), .saved_valid(saved_valid)
   );

   typedef struct {
      bit       chk_fwd;
      bit [3:0] fwd;
      bit [3:0] st;
      bit [3:0] sv;
      bit       svld;
   } exp_t;

   exp_t exp_q[$];

   int passed = 0;
   int total  = 0;

   // Architectural state as the model sees it.
   bit [3:0] m_status = 4'h0;
   bit [3:0] m_saved  = 4'h0;
   bit       m_svld   = 1'b0;

   task automatic check4(input string name, input logic [3:0] act, input bit [3:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
   endtask

   task automatic check1(input string name, input logic act, input bit req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
   endtask

   // Drive one cycle of inputs. Compute the model's view of this cycle and
   // of the state after the coming edge, then queue the expectations.
   task automatic drive(input bit r, input bit fz, input bit fl, input bit s,
                        input bit ar, input bit [DW-1:0] res, input bit c,
                        input bit v, input bit sc, input bit we,
                        input bit [3:0] wd, input bit sv, input bit rs);
      bit [3:0] gen, nxt;
      exp_t     e;
      @(posedge clk);
      #1;
      rst = r; freeze = fz; flush = fl; s_upd = s; arith = ar; alu_result = res;
      alu_c = c; alu_v = v; shift_c = sc; wr_en = we; wr_data = wd;
      save_en = sv; restore_en = rs;

      // Flags from the ALU result: N = sign, Z = whole word is zero.
      gen = {res[DW-1], (res == 0), (ar ? c : sc), (ar ? v : m_status[0])};
      if (rs && m_svld)    nxt = m_saved;
      else if (we)         nxt = wd;
      else if (s && !fl)   nxt = gen;
      else                 nxt = m_status;

      e.chk_fwd = !r;
      e.fwd     = fz ? m_status : nxt;

      if (r) begin
         m_status = 4'h0; m_saved = 4'h0; m_svld = 1'b0;
      end else if (!fz) begin
         if (sv) begin
            m_saved = m_status;
            m_svld  = 1'b1;
         end else if (rs && m_svld) begin
            m_svld = 1'b0;
         end
         m_status = nxt;
      end
      e.st = m_status; e.sv = m_saved; e.svld = m_svld;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      drive(0,0,0,0,0,32'h1,0,0,0,0,4'h0,0,0);
   endtask

   // Monitor
   bit   mon_have_prev = 1'b0;
   exp_t mon_prev, mon_cur;

   initial begin
      forever begin
         @(negedge clk);
         if (mon_have_prev) begin
            check4("status",       status,       mon_prev.st);
            check4("saved_status", saved_status, mon_prev.sv);
            check1("saved_valid",  saved_valid,  mon_prev.svld);
         end
         if (exp_q.size() > 0) begin
            mon_cur = exp_q.pop_front();
            if (mon_cur.chk_fwd) check4("status_fwd", status_fwd, mon_cur.fwd);
            mon_prev      = mon_cur;
            mon_have_prev = 1'b1;
         end else begin
            mon_have_prev = 1'b0;
         end
      end
   end

   function automatic bit [DW-1:0] rand_result();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return 32'h8000_0000;
         2:       return 32'h1 << $urandom_range(0, DW-1);
         3:       return 32'h0001_0000;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      int budget;
      rst = 1; freeze = 0; flush = 0; s_upd = 0; arith = 0; alu_result = '0;
      alu_c = 0; alu_v = 0; shift_c = 0; wr_en = 0; wr_data = 0;
      save_en = 0; restore_en = 0;

      // Reset wins over a concurrent direct write.
      drive(1,0,0,0,0,32'h0,0,0,0,1,4'hF,0,0);
      // Arithmetic zero result with carry: 0110.
      drive(0,0,0,1,1,32'h0,1,0,0,0,4'h0,0,0);
      idle();
      // Logical op keeps V: 0001 then sign result with shifter carry -> 1011.
      drive(0,0,0,0,0,32'h0,0,0,0,1,4'h1,0,0);
      drive(0,0,0,1,0,32'h8000_0000,0,0,1,0,4'h0,0,0);
      // Freeze, then flush, with a zero-result update pending.
      drive(0,1,0,1,1,32'h0,1,1,0,0,4'h0,0,0);
      drive(0,0,1,1,1,32'h0,1,1,0,0,4'h0,0,0);
      // Save / write / restore / second restore.
      drive(0,0,0,0,0,32'h0,0,0,0,1,4'h8,0,0);
      drive(0,0,0,0,0,32'h0,0,0,0,0,4'h0,1,0);
      drive(0,0,0,0,0,32'h0,0,0,0,1,4'h5,0,0);
      drive(0,0,0,0,0,32'h0,0,0,0,0,4'h0,0,1);
      drive(0,0,0,0,0,32'h0,0,0,0,0,4'h0,0,1);
      // Priority: restore beats write and S-update.
      drive(0,0,0,0,0,32'h0,0,0,0,0,4'h0,1,0);
      drive(0,0,0,1,1,32'h0,1,1,0,1,4'hA,0,1);
      // Save and restore together.
      drive(0,0,0,0,0,32'h0,0,0,0,1,4'h3,1,0);
      drive(0,0,0,0,0,32'h0,0,0,0,1,4'hC,1,1);
      idle();

      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
               $urandom_range(0, 1), rand_result(), $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom_range(0, 1),
               ($urandom_range(0, 4) == 0), 4'($urandom()),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
      end
      idle();

      budget = 0;
      while (exp_q.size() > 0 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (exp_q.size() > 0) begin
         total++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      repeat (2) @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_status_flag_unit
